// File: rtl/uart_dummy_pkg.sv
// Shared types for the word-level UART stand-in.
// State encodings and drop-counter width.
package uart_dummy_pkg;

  typedef enum logic {
    TX_IDLE,
    TX_BUSY
  } tx_state_t;

  typedef enum logic {
    RX_GAP,
    RX_WAIT
  } rx_state_t;

  localparam int DROP_W = 16;

endpackage

// File: rtl/dummy_fifo.sv
// First-word fall-through FIFO with occupancy count.
// Fullness is judged on the pre-edge count.
module dummy_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = empty ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q + AW'(push_ok);
    rd_d  = rd_q + AW'(pop_ok);
    cnt_d = cnt_q;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/uart_dummy_link.sv
// Cycle-deterministic word-level UART stand-in for core simulation.
// Source FIFO feeds rx; tx commits to capture FIFO or loops back.
module uart_dummy_link
  import uart_dummy_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int TX_CYCLES = 20,
  parameter int RX_GAP    = 31,
  parameter int SRC_DEPTH = 16,
  parameter int CAP_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          txdata,
  input  logic                       tx_start,
  output logic                       tx_busy,
  output logic                       txd,
  output logic [DATA_W-1:0]          rdata,
  output logic                       rx_ready,
  output logic                       ferr,
  input  logic                       loopback,
  input  logic                       src_push,
  input  logic [DATA_W-1:0]          src_data,
  input  logic                       src_ferr,
  output logic                       src_full,
  input  logic                       cap_pop,
  output logic [DATA_W-1:0]          cap_data,
  output logic                       cap_valid,
  output logic [$clog2(CAP_DEPTH):0] cap_count,
  output logic [DROP_W-1:0]          tx_drops
);

  localparam int TCW = $clog2(TX_CYCLES) + 1;
  localparam int RCW = $clog2(RX_GAP + 1) + 1;
  localparam int SCW = $clog2(SRC_DEPTH) + 1;

  tx_state_t         tx_state_q, tx_state_d;
  logic [TCW-1:0]    tx_cnt_q, tx_cnt_d;
  logic [DATA_W-1:0] tx_word_q, tx_word_d;
  logic              tx_busy_q, tx_busy_d;
  logic [DROP_W-1:0] drops_q, drops_d;

  rx_state_t         rx_state_q, rx_state_d;
  logic [RCW-1:0]    gap_q, gap_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ferr_q, ferr_d;
  logic              rx_ready_q, rx_ready_d;

  logic              commit, dest_full, deliver;
  logic              src_wr, src_full_w, src_empty;
  logic [DATA_W:0]   src_din, src_dout;
  logic [SCW-1:0]    src_count;
  logic              cap_wr, cap_full, cap_empty;

  assign commit    = (tx_state_q == TX_BUSY) &&
                     (tx_cnt_q == TCW'(TX_CYCLES - 1));
  assign dest_full = loopback ? src_full_w : cap_full;
  assign src_wr    = loopback ? commit : src_push;
  assign src_din   = loopback ? {1'b0, tx_word_q}
                              : {src_ferr, src_data};
  assign cap_wr    = commit && !loopback;
  assign deliver   = (rx_state_q == RX_WAIT) && !src_empty;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_word_d  = tx_word_q;
    drops_d    = drops_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_start) begin
          tx_state_d = TX_BUSY;
          tx_cnt_d   = '0;
          tx_word_d  = txdata;
        end
      end
      TX_BUSY: begin
        tx_cnt_d = tx_cnt_q + TCW'(1);
        if (commit) begin
          tx_state_d = TX_IDLE;
          if (dest_full && drops_q != '1)
            drops_d = drops_q + DROP_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    tx_busy_d = (tx_state_d == TX_BUSY);
  end

  always_comb begin
    rx_state_d = rx_state_q;
    gap_d      = gap_q;
    rdata_d    = rdata_q;
    ferr_d     = ferr_q;
    rx_ready_d = 1'b0;
    unique case (rx_state_q)
      uart_dummy_pkg::RX_GAP: begin
        if (gap_q == RCW'(RX_GAP)) rx_state_d = RX_WAIT;
        else gap_d = gap_q + RCW'(1);
      end
      RX_WAIT: begin
        if (deliver) begin
          rx_state_d = uart_dummy_pkg::RX_GAP;
          gap_d      = '0;
          rdata_d    = src_dout[DATA_W-1:0];
          ferr_d     = src_dout[DATA_W];
          rx_ready_d = 1'b1;
        end
      end
      default: rx_state_d = uart_dummy_pkg::RX_GAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_word_q  <= '0;
      tx_busy_q  <= 1'b0;
      drops_q    <= '0;
      rx_state_q <= uart_dummy_pkg::RX_GAP;
      gap_q      <= '0;
      rdata_q    <= '0;
      ferr_q     <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_word_q  <= tx_word_d;
      tx_busy_q  <= tx_busy_d;
      drops_q    <= drops_d;
      rx_state_q <= rx_state_d;
      gap_q      <= gap_d;
      rdata_q    <= rdata_d;
      ferr_q     <= ferr_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  dummy_fifo #(
    .WIDTH(DATA_W + 1),
    .DEPTH(SRC_DEPTH)
  ) u_src (
    .clk  (clk),
    .rst  (rst),
    .push (src_wr),
    .pop  (deliver),
    .din  (src_din),
    .dout (src_dout),
    .full (src_full_w),
    .empty(src_empty),
    .count(src_count)
  );

  dummy_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(CAP_DEPTH)
  ) u_cap (
    .clk  (clk),
    .rst  (rst),
    .push (cap_wr),
    .pop  (cap_pop),
    .din  (tx_word_q),
    .dout (cap_data),
    .full (cap_full),
    .empty(cap_empty),
    .count(cap_count)
  );

  assign tx_busy   = tx_busy_q;
  assign txd       = 1'b1;
  assign rdata     = rdata_q;
  assign ferr      = ferr_q;
  assign rx_ready  = rx_ready_q;
  assign src_full  = (src_count == SCW'(SRC_DEPTH));
  assign cap_valid = !cap_empty;
  assign tx_drops  = drops_q;

endmodule

// File: tb/tb_uart_dummy_link.sv
// Scoreboard bench for uart_dummy_link.
// Expected rx and capture words are queued at stimulus time.
module tb_uart_dummy_link;

  localparam int DATA_W    = 8;
  localparam int TX_CYCLES = 20;
  localparam int RX_GAP    = 31;
  localparam int SRC_DEPTH = 16;
  localparam int CAP_DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] txdata = '0;
  logic              tx_start = 1'b0;
  logic              tx_busy, txd;
  logic [DATA_W-1:0] rdata;
  logic              rx_ready, ferr;
  logic              loopback = 1'b0;
  logic              src_push = 1'b0;
  logic [DATA_W-1:0] src_data = '0;
  logic              src_ferr = 1'b0;
  logic              src_full;
  logic              cap_pop = 1'b0;
  logic [DATA_W-1:0] cap_data;
  logic              cap_valid;
  logic [4:0]        cap_count;
  logic [15:0]       tx_drops;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel = 0;
  logic [8:0] exp_q[$];
  logic [7:0] cap_q[$];
  int rx_times[$];
  logic [8:0] mon_e;

  uart_dummy_link #(
    .DATA_W(DATA_W), .TX_CYCLES(TX_CYCLES), .RX_GAP(RX_GAP),
    .SRC_DEPTH(SRC_DEPTH), .CAP_DEPTH(CAP_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .txdata(txdata), .tx_start(tx_start),
    .tx_busy(tx_busy), .txd(txd), .rdata(rdata),
    .rx_ready(rx_ready), .ferr(ferr), .loopback(loopback),
    .src_push(src_push), .src_data(src_data),
    .src_ferr(src_ferr), .src_full(src_full),
    .cap_pop(cap_pop), .cap_data(cap_data),
    .cap_valid(cap_valid), .cap_count(cap_count),
    .tx_drops(tx_drops)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && rx_ready) begin
      rx_times.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected got %h_%h want none",
                 ferr, rdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({ferr, rdata} !== mon_e) begin
          errors++;
          $display("FAIL rx_word got %h want %h",
                   {ferr, rdata}, mon_e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tx_start = 1'b0;
    src_push = 1'b0;
    cap_pop = 1'b0;
    loopback = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    cap_q.delete();
    rst = 1'b0;
    rel = cyc;
  endtask

  task automatic send_word(input logic [7:0] w,
                           input bit pop_at_commit);
    txdata = w;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    repeat (TX_CYCLES - 1) tick();
    if (pop_at_commit) cap_pop = 1'b1;
    tick();
    if (pop_at_commit) begin
      cap_pop = 1'b0;
      void'(cap_q.pop_front());
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({tx_busy, txd, rx_ready, ferr, src_full, cap_valid}
        !== 6'b010000) begin
      errors++;
      $display("FAIL reset_flags got %b want 010000",
               {tx_busy, txd, rx_ready, ferr, src_full, cap_valid});
    end
    checks++;
    if (rdata !== 8'h00 || cap_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got %h/%h want 00/00",
               rdata, cap_data);
    end
    checks++;
    if (cap_count !== 5'd0 || tx_drops !== 16'd0) begin
      errors++;
      $display("FAIL reset_counts got %0d/%0d want 0/0",
               cap_count, tx_drops);
    end
  endtask

  task automatic test_rx_single();
    while (cyc < rel + 40) tick();
    src_data = 8'hA5;
    src_ferr = 1'b0;
    src_push = 1'b1;
    exp_q.push_back(9'h0A5);
    tick();
    src_push = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL rx_early got %b want 0", rx_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || cyc != rel + 42) begin
      errors++;
      $display("FAIL rx_latency got %b@%0d want 1@%0d",
               rx_ready, cyc - rel, 42);
    end
    while (cyc < rel + 100) tick();
    @(negedge clk);
    checks++;
    if (rdata !== 8'hA5 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL rx_hold got %h/%b want a5/0",
               rdata, rx_ready);
    end
  endtask

  task automatic test_rx_burst();
    int n0;
    logic [7:0] ws [3];
    ws[0] = 8'h11;
    ws[1] = 8'h22;
    ws[2] = 8'h33;
    n0 = rx_times.size();
    for (int i = 0; i < 3; i++) begin
      src_data = ws[i];
      src_ferr = (i == 2);
      src_push = 1'b1;
      exp_q.push_back({(i == 2) ? 1'b1 : 1'b0, ws[i]});
      tick();
    end
    src_push = 1'b0;
    src_ferr = 1'b0;
    repeat (110) tick();
    @(negedge clk);
    checks++;
    if (rx_times.size() != n0 + 3) begin
      errors++;
      $display("FAIL burst_count got %0d want 3",
               rx_times.size() - n0);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (rx_times[n0+i] - rx_times[n0+i-1] != RX_GAP + 2) begin
          errors++;
          $display("FAIL burst_spacing got %0d want %0d",
                   rx_times[n0+i] - rx_times[n0+i-1], RX_GAP + 2);
        end
      end
    end
    checks++;
    if (ferr !== 1'b1 || rdata !== 8'h33) begin
      errors++;
      $display("FAIL burst_last got %b/%h want 1/33",
               ferr, rdata);
    end
  endtask

  task automatic test_tx_capture();
    int bad;
    int busy_n;
    bad = 0;
    busy_n = 0;
    loopback = 1'b0;
    txdata = 8'h5C;
    tx_start = 1'b1;
    cap_q.push_back(8'h5C);
    for (int k = 1; k <= TX_CYCLES + 2; k++) begin
      tick();
      if (k == 1) tx_start = 1'b0;
      @(negedge clk);
      if (tx_busy === 1'b1) busy_n++;
      if (tx_busy !== (k <= TX_CYCLES)) bad++;
      if (k == TX_CYCLES) begin
        checks++;
        if (cap_valid !== 1'b0) begin
          errors++;
          $display("FAIL tx_early_commit got %b want 0",
                   cap_valid);
        end
      end
    end
    checks++;
    if (bad != 0 || busy_n != TX_CYCLES) begin
      errors++;
      $display("FAIL tx_busy_len got %0d want %0d",
               busy_n, TX_CYCLES);
    end
    checks++;
    if (cap_valid !== 1'b1 || cap_data !== cap_q[0] ||
        cap_count !== 5'd1) begin
      errors++;
      $display("FAIL tx_capture got %b/%h/%0d want 1/%h/1",
               cap_valid, cap_data, cap_count, cap_q[0]);
    end
    cap_pop = 1'b1;
    tick();
    cap_pop = 1'b0;
    void'(cap_q.pop_front());
    @(negedge clk);
    checks++;
    if (cap_valid !== 1'b0 || cap_data !== 8'h00 ||
        cap_count !== 5'd0) begin
      errors++;
      $display("FAIL cap_pop got %b/%h/%0d want 0/00/0",
               cap_valid, cap_data, cap_count);
    end
  endtask

  task automatic test_loopback();
    int n0;
    n0 = rx_times.size();
    loopback = 1'b1;
    src_data = 8'hEE;
    src_ferr = 1'b1;
    src_push = 1'b1;
    exp_q.push_back(9'h0C3);
    send_word(8'hC3, 1'b0);
    repeat (40) tick();
    src_push = 1'b0;
    src_ferr = 1'b0;
    tick();
    loopback = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_times.size() != n0 + 1) begin
      errors++;
      $display("FAIL loop_count got %0d want 1",
               rx_times.size() - n0);
    end
    checks++;
    if (rdata !== 8'hC3 || ferr !== 1'b0 ||
        cap_valid !== 1'b0) begin
      errors++;
      $display("FAIL loop_word got %h/%b/%b want c3/0/0",
               rdata, ferr, cap_valid);
    end
  endtask

  task automatic test_back_to_back_overflow();
    logic [7:0] w;
    for (int i = 0; i < CAP_DEPTH; i++) begin
      w = 8'($urandom_range(0, 255));
      cap_q.push_back(w);
      send_word(w, 1'b0);
    end
    @(negedge clk);
    checks++;
    if (cap_count !== 5'd16 || tx_drops !== 16'd0) begin
      errors++;
      $display("FAIL fill got %0d/%0d want 16/0",
               cap_count, tx_drops);
    end
    send_word(8'hEE, 1'b1);
    @(negedge clk);
    checks++;
    if (tx_drops !== 16'd1 || cap_count !== 5'd15) begin
      errors++;
      $display("FAIL overflow got %0d/%0d want 1/15",
               tx_drops, cap_count);
    end
    while (cap_q.size() > 0) begin
      @(negedge clk);
      checks++;
      if (cap_valid !== 1'b1 || cap_data !== cap_q[0]) begin
        errors++;
        $display("FAIL drain got %b/%h want 1/%h",
                 cap_valid, cap_data, cap_q[0]);
      end
      cap_pop = 1'b1;
      tick();
      cap_pop = 1'b0;
      void'(cap_q.pop_front());
    end
    @(negedge clk);
    checks++;
    if (cap_valid !== 1'b0 || cap_count !== 5'd0) begin
      errors++;
      $display("FAIL drain_end got %b/%0d want 0/0",
               cap_valid, cap_count);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    int bad;
    bit seen;
    n0 = rx_times.size();
    seen = 0;
    src_data = 8'h42;
    src_push = 1'b1;
    exp_q.push_back(9'h042);
    tick();
    src_push = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      tick();
      @(negedge clk);
      if (rx_times.size() > n0) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_setup got timeout want rx_ready");
    end
    tick();
    for (int j = 0; j < 3; j++) begin
      src_data = 8'(8'h60 + j);
      src_push = 1'b1;
      exp_q.push_back({1'b0, 8'(8'h60 + j)});
      tick();
    end
    src_push = 1'b0;
    txdata = 8'h77;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    rel = cyc;
    @(negedge clk);
    checks++;
    if ({tx_busy, txd, rx_ready, ferr, src_full, cap_valid}
        !== 6'b010000 || rdata !== 8'h00) begin
      errors++;
      $display("FAIL mid_flags got %b/%h want 010000/00",
               {tx_busy, txd, rx_ready, ferr, src_full, cap_valid},
               rdata);
    end
    checks++;
    if (cap_count !== 5'd0 || tx_drops !== 16'd0) begin
      errors++;
      $display("FAIL mid_counts got %0d/%0d want 0/0",
               cap_count, tx_drops);
    end
    n0 = rx_times.size();
    repeat (TX_CYCLES + RX_GAP + 10) tick();
    @(negedge clk);
    checks++;
    if (rx_times.size() != n0 || cap_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_discard got %0d/%b want 0/0",
               rx_times.size() - n0, cap_valid);
    end
    do_reset();
    src_data = 8'h9A;
    src_push = 1'b1;
    exp_q.push_back(9'h09A);
    bad = 0;
    for (int k = 1; k <= RX_GAP + 2; k++) begin
      tick();
      if (k == 1) src_push = 1'b0;
      @(negedge clk);
      if (k <= RX_GAP + 1 && rx_ready !== 1'b0) bad++;
      if (k == RX_GAP + 2) begin
        checks++;
        if (rx_ready !== 1'b1) begin
          errors++;
          $display("FAIL gap_first got %b want 1", rx_ready);
        end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL gap_quiet got %0d early want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_rx_single();
    test_rx_burst();
    test_tx_capture();
    test_loopback();
    test_back_to_back_overflow();
    test_reset_mid();
    repeat (4) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rx_pending got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
